// File: rtl/block_layer_renderer.sv
// Brick-field renderer: scan position -> cell address -> block code -> pixel.
// Three-stage pipeline matched to a block map with one registered read cycle,
// plus a single-slot flash animation for the most recently hit cell.
module block_layer_renderer #(
  parameter int LEFT         = 64,
  parameter int TOP          = 0,
  parameter int COLS         = 10,
  parameter int ROWS         = 30,
  parameter int CW_LOG2      = 5,
  parameter int CH_LOG2      = 4,
  parameter int COL_W        = 5,
  parameter int ROW_W        = 5,
  parameter int FLASH_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       hcounter,
  input  logic [9:0]       vcounter,
  input  logic             pix_valid,
  input  logic             frame_start,
  input  logic             hit_valid,
  input  logic [ROW_W-1:0] hit_row,
  input  logic [COL_W-1:0] hit_col,
  output logic [ROW_W-1:0] sel_row,
  output logic [COL_W-1:0] sel_col,
  input  logic [2:0]       block,
  output logic [3:0]       out,
  output logic             out_valid
);

  localparam int CW    = 1 << CW_LOG2;
  localparam int CH    = 1 << CH_LOG2;
  localparam int I_LO  = CW / 4;
  localparam int I_HI  = (3 * CW) / 4 - 1;
  localparam int RIGHT = LEFT + COLS * CW;
  localparam int BOT   = TOP + ROWS * CH;

  // Stage 1 combinational decode: shifts and masks only, no dividers.
  logic [9:0]         dx, dy;
  logic               area_c;
  logic [COL_W-1:0]   col_c;
  logic [ROW_W-1:0]   row_c;

  assign dx     = hcounter - 10'(LEFT);
  assign dy     = vcounter - 10'(TOP);
  assign area_c = (32'(hcounter) >= LEFT) && (32'(hcounter) < RIGHT) &&
                  (32'(vcounter) >= TOP)  && (32'(vcounter) < BOT);
  assign col_c  = COL_W'(dx >> CW_LOG2);
  assign row_c  = ROW_W'(dy >> CH_LOG2);

  // Pipeline state.
  logic [CW_LOG2-1:0] s1_i, s2_i;
  logic [CH_LOG2-1:0] s1_j, s2_j;
  logic               s1_in, s2_in, s1_valid, s2_valid;
  logic               s2_match, s2_flash_even;

  // Flash slot.
  logic [ROW_W-1:0]   fl_row;
  logic [COL_W-1:0]   fl_col;
  logic [7:0]         fl_cnt;
  logic               hit_ok;

  assign hit_ok = hit_valid && (32'(hit_row) < ROWS) && (32'(hit_col) < COLS);

  // Stage 1: register the map address and the in-cell offsets.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every stage samples
    // the previous stage's pre-edge value; blocking here would collapse stages.
    if (rst) begin
      sel_row  <= '0;
      sel_col  <= '0;
      s1_i     <= '0;
      s1_j     <= '0;
      s1_in    <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      sel_row  <= (area_c && pix_valid) ? row_c : '0;
      sel_col  <= (area_c && pix_valid) ? col_c : '0;
      s1_i     <= dx[CW_LOG2-1:0];
      s1_j     <= dy[CH_LOG2-1:0];
      s1_in    <= area_c;
      s1_valid <= pix_valid;
    end
  end

  // Stage 2: delay offsets while the map reads; compare against the flash slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_i          <= '0;
      s2_j          <= '0;
      s2_in         <= 1'b0;
      s2_valid      <= 1'b0;
      s2_match      <= 1'b0;
      s2_flash_even <= 1'b0;
    end else begin
      s2_i          <= s1_i;
      s2_j          <= s1_j;
      s2_in         <= s1_in;
      s2_valid      <= s1_valid;
      s2_match      <= (fl_cnt != 8'd0) && (sel_row == fl_row) && (sel_col == fl_col);
      s2_flash_even <= ~fl_cnt[0];
    end
  end

  // Flash slot: a valid hit loads and wins over a same-cycle frame decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      fl_row <= '0;
      fl_col <= '0;
      fl_cnt <= 8'd0;
    end else if (hit_ok) begin
      fl_row <= hit_row;
      fl_col <= hit_col;
      fl_cnt <= 8'(FLASH_FRAMES);
    end else if (frame_start && fl_cnt != 8'd0) begin
      fl_cnt <= fl_cnt - 8'd1;
    end
  end

  // Stage 3 combinational: pixel shading from the block code and offsets.
  logic [3:0] pix_c;
  logic       edge_j, edge_i_wide;

  assign edge_j      = (s2_j == '0) || (s2_j == CH_LOG2'(CH - 1));
  assign edge_i_wide = (s2_i == '0) || (s2_i == CW_LOG2'(CW - 1));

  // Shade the pixel; flash overrides the map code for the whole flash cell.
  always_comb begin
    // NOTE: default assigned first so every path drives pix_c and no latch forms.
    pix_c = 4'b0000;
    if (s2_valid && s2_in) begin
      if (s2_match) begin
        pix_c = s2_flash_even ? 4'b1111 : 4'b0000;
      end else if (block == 3'b000) begin
        pix_c = 4'b0000;
      end else if (!block[2]) begin
        if (s2_i == CW_LOG2'(I_LO) || s2_i == CW_LOG2'(I_HI)) begin
          pix_c = 4'b1000;
        end else if (s2_i > CW_LOG2'(I_LO) && s2_i < CW_LOG2'(I_HI)) begin
          if (edge_j) begin
            pix_c = 4'b1000;
          end else begin
            case (block[1:0])
              2'b01:   pix_c = 4'b1100;
              2'b10:   pix_c = 4'b1110;
              default: pix_c = 4'b1101;
            endcase
          end
        end
      end else begin
        if (edge_i_wide || edge_j) begin
          pix_c = 4'b1000;
        end else begin
          case (block[1:0])
            2'b00:   pix_c = 4'b1001;
            2'b01:   pix_c = 4'b1011;
            2'b10:   pix_c = 4'b1010;
            default: pix_c = 4'b1111;
          endcase
        end
      end
    end
  end

  // Stage 3: output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= 4'b0000;
      out_valid <= 1'b0;
    end else begin
      out       <= pix_c;
      out_valid <= s2_valid;
    end
  end

endmodule

// File: tb/tb_block_layer_renderer.sv
// Directed bench for block_layer_renderer with a one-cycle registered map model.
module tb_block_layer_renderer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hcounter = '0, vcounter = '0;
  logic       pix_valid = 1'b0, frame_start = 1'b0, hit_valid = 1'b0;
  logic [4:0] hit_row = '0, hit_col = '0;
  logic [4:0] sel_row, sel_col;
  logic [2:0] block = '0;
  logic [3:0] out;
  logic       out_valid;

  int errors = 0;
  int checks = 0;

  logic [2:0] map [0:31][0:31];

  block_layer_renderer dut (
    .clk(clk), .rst(rst), .hcounter(hcounter), .vcounter(vcounter),
    .pix_valid(pix_valid), .frame_start(frame_start), .hit_valid(hit_valid),
    .hit_row(hit_row), .hit_col(hit_col), .sel_row(sel_row), .sel_col(sel_col),
    .block(block), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Block map with exactly one registered read cycle.
  always @(posedge clk) block <= map[sel_row][sel_col];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic pv);
    hcounter = h; vcounter = v; pix_valid = pv;
    @(posedge clk); #1;
  endtask

  task automatic pix(input string tag, input logic [9:0] h, input logic [9:0] v,
                     input logic [3:0] e);
    step(h, v, 1'b1);
    step(10'd0, 10'd0, 1'b0);
    step(10'd0, 10'd0, 1'b0);
    check(tag, 32'(out), 32'(e));
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic hit(input logic [4:0] r, input logic [4:0] c, input logic fs);
    hit_valid = 1'b1; hit_row = r; hit_col = c; frame_start = fs;
    step(10'd0, 10'd0, 1'b0);
    hit_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step(10'd0, 10'd0, 1'b0);
    frame_start = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        map[r][c] = 3'b000;
    map[0][0]  = 3'b010;
    map[0][9]  = 3'b101;
    map[2][3]  = 3'b101;
    map[2][4]  = 3'b101;
    map[29][3] = 3'b111;

    // Power-up reset.
    step(10'd160, 10'd37, 1'b1);
    step(10'd161, 10'd37, 1'b1);
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sel_col", 32'(sel_col), 32'd0);
    check("rst_sel_row", 32'(sel_row), 32'd0);
    rst = 1'b0;
    step(10'd0, 10'd0, 1'b0);
    step(10'd0, 10'd0, 1'b0);
    step(10'd0, 10'd0, 1'b0);

    // Wide cell at row 2, col 3.
    step(10'd160, 10'd37, 1'b1);
    check("wide_sel_col", 32'(sel_col), 32'd3);
    check("wide_sel_row", 32'(sel_row), 32'd2);
    step(10'd161, 10'd37, 1'b1);
    step(10'd0, 10'd0, 1'b0);
    check("wide_border", 32'(out), 32'b1000);
    step(10'd0, 10'd0, 1'b0);
    check("wide_body", 32'(out), 32'b1011);

    // Narrow cell at row 0, col 0.
    pix("narrow_i8", 10'd72, 10'd5, 4'b1000);
    pix("narrow_i12_j5", 10'd76, 10'd5, 4'b1110);
    pix("narrow_i12_j0", 10'd76, 10'd0, 4'b1000);
    pix("narrow_i4", 10'd68, 10'd5, 4'b0000);

    // Grid boundaries.
    step(10'd383, 10'd5, 1'b1);
    check("right_edge_sel_col", 32'(sel_col), 32'd9);
    step(10'd0, 10'd0, 1'b0);
    step(10'd0, 10'd0, 1'b0);
    check("right_edge_out", 32'(out), 32'b1000);
    step(10'd384, 10'd5, 1'b1);
    check("past_right_sel_col", 32'(sel_col), 32'd0);
    pix("past_right_out", 10'd384, 10'd5, 4'b0000);
    pix("before_left_out", 10'd63, 10'd5, 4'b0000);
    step(10'd160, 10'd479, 1'b1);
    check("bottom_sel_row", 32'(sel_row), 32'd29);
    step(10'd0, 10'd0, 1'b0);
    step(10'd0, 10'd0, 1'b0);
    check("bottom_out", 32'(out), 32'b1000);
    step(10'd160, 10'd480, 1'b1);
    check("past_bottom_sel_row", 32'(sel_row), 32'd0);
    pix("past_bottom_out", 10'd160, 10'd480, 4'b0000);
    pix("invalid_pixel_area", 10'd161, 10'd37, 4'b1011);
    step(10'd161, 10'd37, 1'b0);
    check("invalid_sel_col", 32'(sel_col), 32'd0);
    step(10'd0, 10'd0, 1'b0);
    step(10'd0, 10'd0, 1'b0);
    check("invalid_out", 32'(out), 32'd0);
    check("invalid_out_valid", 32'(out_valid), 32'd0);

    // Reset mid-line discards in-flight pixels and the flash.
    hit(5'd2, 5'd3, 1'b0);
    step(10'd161, 10'd37, 1'b1);
    step(10'd162, 10'd37, 1'b1);
    rst = 1'b1;
    step(10'd163, 10'd37, 1'b1);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sel_col", 32'(sel_col), 32'd0);
    check("midrst_sel_row", 32'(sel_row), 32'd0);
    step(10'd164, 10'd37, 1'b1);
    rst = 1'b0;
    step(10'd165, 10'd37, 1'b1);
    check("post_rst_sel_col", 32'(sel_col), 32'd3);
    check("post_rst_out_valid_a", 32'(out_valid), 32'd0);
    step(10'd0, 10'd0, 1'b0);
    check("post_rst_out_valid_b", 32'(out_valid), 32'd0);
    step(10'd0, 10'd0, 1'b0);
    check("post_rst_first_out", 32'(out), 32'b1011);
    check("post_rst_fl_cnt", 32'(dut.fl_cnt), 32'd0);
    pix("post_rst_no_flash", 10'd161, 10'd37, 4'b1011);

    // Flash sequence on an already-cleared cell.
    map[2][3] = 3'b000;
    pix("cleared_cell", 10'd165, 10'd37, 4'b0000);
    hit(5'd2, 5'd3, 1'b0);
    pix("flash_start", 10'd165, 10'd37, 4'b1111);
    pix("flash_other_cell", 10'd200, 10'd37, 4'b1011);
    for (int k = 1; k <= 8; k++) begin
      frame();
      pix($sformatf("flash_frame%0d", k), 10'd165, 10'd37,
          ((k % 2) == 0 && k != 8) ? 4'b1111 : 4'b0000);
    end
    check("flash_done_cnt", 32'(dut.fl_cnt), 32'd0);
    frame();
    check("idle_frame_cnt", 32'(dut.fl_cnt), 32'd0);

    // Simultaneous hit and frame pulse: the load wins.
    hit(5'd2, 5'd3, 1'b0);
    for (int k = 0; k < 5; k++) frame();
    check("cnt_before_sim", 32'(dut.fl_cnt), 32'd3);
    hit(5'd2, 5'd3, 1'b1);
    check("sim_hit_frame_cnt", 32'(dut.fl_cnt), 32'd8);
    hit(5'd2, 5'd12, 1'b0);
    check("oob_col_ignored", 32'(dut.fl_cnt), 32'd8);
    frame();
    hit(5'd30, 5'd3, 1'b0);
    check("oob_row_ignored", 32'(dut.fl_cnt), 32'd7);
    pix("odd_cnt_dark", 10'd165, 10'd37, 4'b0000);

    // A new hit restarts the flash at the new cell.
    hit(5'd2, 5'd4, 1'b0);
    check("restart_cnt", 32'(dut.fl_cnt), 32'd8);
    pix("restart_new_cell", 10'd200, 10'd37, 4'b1111);
    pix("restart_old_cell", 10'd165, 10'd37, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_layer_renderer.md
# block_layer_renderer

Pipelined, parametrised renderer for the brick field in the Arkanoid VGA path. It converts the scan position into a cell address, reads the block code from the synchronous block map, and produces one 4-bit `{v,r,g,b}` pixel per clock. Cell geometry, grid size and origin are generalised. It adds a per-hit flash animation driven by frame pulses. It sits between the VGA timing generator and the pixel mixer, alongside the ball and paddle drawers.

## Interface
- `LEFT`, 64, x origin of grid in pixels
- `TOP`, 0, y origin of grid in pixels
- `COLS`, 10, grid columns (≤ 2^COL_W)
- `ROWS`, 30, grid rows (≤ 2^ROW_W)
- `CW_LOG2`, 5, log2 cell width (cell width CW = 32)
- `CH_LOG2`, 4, log2 cell height (cell height CH = 16)
- `COL_W`, 5, width of column index
- `ROW_W`, 5, width of row index
- `FLASH_FRAMES`, 8, frames a hit cell flashes (even, 2..255)
- `clk`  in  1  pixel clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `hcounter`  in  10  current pixel x
- `vcounter`  in  10  current pixel y
- `pix_valid`  in  1  hcounter/vcounter describe a visible pixel
- `frame_start`  in  1  one-cycle pulse per frame
- `hit_valid`  in  1  one-cycle pulse: ball hit a block
- `hit_row` / `hit_col`  in  ROW_W / COL_W  cell that was hit
- `sel_row` / `sel_col`  out  ROW_W / COL_W  registered block-map address
- `block`  in  3  block code from map, valid the cycle after `sel_*` updates
- `out`  out  4  `{v,r,g,b}` pixel
- `out_valid`  out  1  `out` corresponds to a `pix_valid` pixel

## Operation
- In area: `LEFT ≤ hcounter < LEFT+COLS*CW` and `TOP ≤ vcounter < TOP+ROWS*CH`.
- Cell coordinates use shifts and masks, with no dividers:
  - col = (hcounter−LEFT)>>CW_LOG2, i = low CW_LOG2 bits.
  - row = (vcounter−TOP)>>CH_LOG2, j = low CH_LOG2 bits.
- Stage 1: registers `sel_col`/`sel_row`, i, j, in_area and pix_valid. Out of area or pix_valid=0 forces `sel_*`=0.
- Stage 2: the map registers `block` internally. Delayed i, j, in_area, valid, plus a cell-match flag for the flash cell.
- Stage 3: output register, computing the pixel from `block`.
  - Not valid or out of area → 0000.
  - `block`=000 → 0000.
  - Narrow (`block[2]`=0):
    - i == CW/4 or i == 3CW/4−1 → 1000.
    - CW/4 < i < 3CW/4−1: j == 0 or CH−1 → 1000; otherwise colour by `block[1:0]`: 01→1100, 10→1110, 11→1101.
    - Anything else → 0000.
  - Wide (`block[2]`=1):
    - i ∈ {0, CW−1} or j ∈ {0, CH−1} → 1000.
    - Body by `block[1:0]`: 00→1001, 01→1011, 10→1010, 11→1111.
- Flash unit: one slot holding `fl_row`, `fl_col` and an 8-bit `fl_cnt`.
  - `hit_valid` with row<ROWS and col<COLS loads the coordinates and sets `fl_cnt`=FLASH_FRAMES.
  - An out-of-range hit is ignored.
  - `frame_start` with `fl_cnt`≠0 decrements `fl_cnt`.
  - `hit_valid` and `frame_start` in the same cycle: the load wins and no decrement happens.
  - A new hit during a flash restarts the flash at the new cell.
  - While `fl_cnt`≠0, every in-area pixel of the flash cell overrides the block code. `fl_cnt` even → 1111; odd → 0000. This applies even if `block`=000, since the map is already cleared.

## Timing
- Reset (next edge) clears `sel_row`=0, `sel_col`=0, `out`=0, `out_valid`=0, `fl_cnt`=0, and all pipeline valids.
- Reset mid-line discards in-flight pixels. Outputs stay at 0 until new pixels traverse the pipeline.
- Latency from `hcounter`/`vcounter`/`pix_valid` to `out`/`out_valid`:
  - Edge k: `sel_*` register.
  - Edge k+1: `block` valid.
  - Edge k+2: `out` and `out_valid` register.
  - Throughput: one pixel per clock with no stalls.
- The map must return `block` for the address presented after edge k before edge k+2. Its read latency is exactly one registered cycle.
- The flash state compared at stage 2 is the value present at that edge. A hit takes effect on pixels reaching stage 2 after the load edge.

## Test plan
- Reset: hold `rst` for 2 cycles during active scan → `out`=0000, `out_valid`=0, `sel_*`=0; no flash after release.
- Wide cell: hcounter=160, vcounter=37, `block`=101 → `sel_col`=3, `sel_row`=2; `out`=1000 two cycles later. Next pixel, hcounter=161 → 1011.
- Narrow cell at row 0, col 0, `block`=010:
  - i=8 → 1000.
  - i=12, j=5 → 1110.
  - i=12, j=0 → 1000.
  - i=4 → 0000.
- Boundaries:
  - hcounter=383 → `sel_col`=9, in area.
  - hcounter=384 or 63 → `out`=0000, `sel_*`=0.
  - vcounter=479 in area; vcounter=480 out of area.
- Flash sequence: `hit_valid` at row 2, col 3, with `block`=000 in that cell.
  - Cell renders 1111 until the first `frame_start`, then 0000, then alternates.
  - After 8 `frame_start` pulses, normal rendering (0000) resumes.
  - Other cells are unaffected.
- Simultaneous events:
  - `hit_valid` and `frame_start` in the same cycle with `fl_cnt`=3 → `fl_cnt`=8.
  - `hit_valid` with `hit_col`=12 → ignored; `fl_cnt` unchanged.
